reg_bus_arbiter: RTL

//  Arbitrates the shared config/status register bank between two serial front-ends:

---
 rtl/reg_bus_pkg.sv | 22 ++
 rtl/rr_pick2.sv | 25 ++
 rtl/reg_bus_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the register-bank arbiter.
// Request fields are sized by the default bank geometry below.
package reg_bus_pkg;
    localparam int REG_ADDR_W = 8;
    localparam int REG_DATA_W = 8;

    localparam logic M_SPI = 1'b0;
    localparam logic M_I2C = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                  wr_rdn;
        logic                  lock;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] wdata;
    } reg_req_t;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker with lock override.
// A held lock masks the non-owner entirely, even if the owner is not requesting.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock_valid,
    input  logic       lock_owner,
    output logic       gnt_valid,
    output logic       gnt_idx
);
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
        if (lock_valid) begin
            gnt_valid = req[lock_owner];
            gnt_idx   = lock_owner;
        end else if (req == 2'b11) begin
            gnt_valid = 1'b1;
            gnt_idx   = ~last;
        end else begin
            gnt_valid = |req;
            gnt_idx   = req[1];
        end
    end
endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin, lock-capable access controller between the SPI and I2C
// register front-ends and the shared config/status register bank.
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int ADDR_W       = REG_ADDR_W,
    parameter int REG_W        = REG_DATA_W,
    parameter int LOCK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic              m0_req,
    input  logic              m0_wr_rdn,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [REG_W-1:0]  m0_wdata,
    output logic              m0_ack,
    output logic [REG_W-1:0]  m0_rdata,
    input  logic              m1_req,
    input  logic              m1_wr_rdn,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [REG_W-1:0]  m1_wdata,
    output logic              m1_ack,
    output logic [REG_W-1:0]  m1_rdata,
    output logic              bank_we,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [REG_W-1:0]  bank_wdata,
    input  logic [REG_W-1:0]  bank_rdata,
    output logic              busy,
    output logic              owner,
    output logic              lock_timeout,
    output logic [1:0]        dbg_state
);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    arb_state_t       state, state_nxt;
    reg_req_t         cur_q, sel_req;
    logic             win_q, last_q, lock_valid_q, lock_owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic             gnt_valid, gnt_idx, grant;
    logic [1:0]       req_vec;

    assign req_vec = {m1_req, m0_req};
    assign grant   = (state == IDLE) && ena && gnt_valid;

    rr_pick2 u_pick (
        .req        (req_vec),
        .last       (last_q),
        .lock_valid (lock_valid_q),
        .lock_owner (lock_owner_q),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    always_comb begin
        if (gnt_idx == M_I2C) sel_req = '{m1_wr_rdn, m1_lock, m1_addr, m1_wdata};
        else                  sel_req = '{m0_wr_rdn, m0_lock, m0_addr, m0_wdata};
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ACCESS;
            ACCESS:  state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bank_we   = (state == ACCESS) && cur_q.wr_rdn;
        m0_ack    = (state == ACK) && (win_q == M_SPI);
        m1_ack    = (state == ACK) && (win_q == M_I2C);
        busy      = (state != IDLE) || lock_valid_q;
        dbg_state = state;
    end

    // Captured request drives the bank until the next grant replaces it.
    assign bank_addr  = cur_q.addr;
    assign bank_wdata = cur_q.wdata;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cur_q        <= '0;
            win_q        <= 1'b0;
            owner        <= 1'b0;
            last_q       <= 1'b1;
            lock_valid_q <= 1'b0;
            lock_owner_q <= 1'b0;
            cnt_q        <= '0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
            lock_timeout <= 1'b0;
        end else begin
            if (grant) begin
                cur_q <= sel_req;
                win_q <= gnt_idx;
                owner <= gnt_idx;
            end
            if (state == ACCESS && !cur_q.wr_rdn) begin
                if (win_q == M_I2C) m1_rdata <= bank_rdata;
                else                m0_rdata <= bank_rdata;
            end
            if (state == ACK) begin
                last_q       <= win_q;
                lock_valid_q <= cur_q.lock;
                lock_owner_q <= win_q;
                cnt_q        <= '0;
            end else if (state == IDLE && lock_valid_q && !req_vec[lock_owner_q]) begin
                // Owner has gone quiet: count towards forced release.
                if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    lock_valid_q <= 1'b0;
                    lock_timeout <= 1'b1;
                    cnt_q        <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end
endmodule
